// File: rtl/cnn_pkg.sv
// Shared constants and state encodings for the CNN image path.
// cnn_core and the image loader both size their buffers from IMG_BITS/IMG_BYTES.
package cnn_pkg;

    localparam int unsigned IMG_BITS   = 784;
    localparam int unsigned IMG_BYTES  = 98;
    localparam int unsigned BYTE_CNT_W = 7;   // counts 0..IMG_BYTES-1
    localparam int unsigned PIX_CNT_W  = 10;  // counts 0..IMG_BITS-1

    // Image loader states.
    typedef enum logic [1:0] {
        LOAD,
        WAIT_CORE,
        STREAM
    } ld_state_t;

    // UART receiver states.
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver. RX is synchronized with two flops, a start edge is qualified
// half a bit later, then data and stop bits are sampled at mid-bit. A good frame
// yields a one-cycle rx_vld with the byte; a low stop bit yields a one-cycle rx_ferr.
module uart_rx
    import cnn_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    output logic [7:0] rx_data,
    output logic       rx_vld,
    output logic       rx_ferr
);

    localparam int unsigned CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BAUD_DIV - 1);

    logic [1:0]       sync_q;
    logic             rx_s;
    logic             rx_prev_q;
    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_data_d;
    logic             rx_vld_d;
    logic             rx_ferr_d;

    assign rx_s = sync_q[1];

    // Two-flop synchronizer plus a delayed copy for falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[0], RX};
            rx_prev_q <= rx_s;
        end
    end

    // Receiver state, counters and output pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            rx_data <= '0;
            rx_vld  <= 1'b0;
            rx_ferr <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            rx_data <= rx_data_d;
            rx_vld  <= rx_vld_d;
            rx_ferr <= rx_ferr_d;
        end
    end

    // Next-state logic: frame sequencing and mid-bit sampling.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        rx_data_d = rx_data;
        rx_vld_d  = 1'b0;
        rx_ferr_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rx_prev_q && !rx_s) begin
                    state_d = START;
                    baud_d  = '0;
                end
            end
            START: begin
                if (baud_q == HALF_CNT) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    // A line that is high again at mid start bit was only a glitch.
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (baud_q == FULL_CNT) begin
                    baud_d  = '0;
                    shift_d = {rx_s, shift_q[7:1]};  // LSB arrives first
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (baud_q == FULL_CNT) begin
                    baud_d  = '0;
                    state_d = IDLE;
                    if (rx_s) begin
                        rx_vld_d  = 1'b1;
                        rx_data_d = shift_q;
                    end else begin
                        rx_ferr_d = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/cnn_img_loader.sv
// Receives a binarized 28x28 image over UART, packs it into a 784-bit buffer and,
// once cnn_core is idle, pulses strt and streams the image one pixel per clock.
module cnn_img_loader
    import cnn_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic RX,
    input  logic bsy,
    output logic strt,
    output logic din,
    output logic rx_err
);

    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(IMG_BYTES - 1);
    localparam logic [PIX_CNT_W-1:0]  LAST_PIX  = PIX_CNT_W'(IMG_BITS - 1);

    logic [7:0]            rx_data;
    logic                  rx_vld;
    logic                  rx_ferr;

    ld_state_t             state_q, state_d;
    logic [IMG_BITS-1:0]   img_q, img_d;
    logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [PIX_CNT_W-1:0]  pix_cnt_q, pix_cnt_d;

    uart_rx #(
        .BAUD_DIV(BAUD_DIV)
    ) u_uart_rx (
        .clk    (clk),
        .rst    (rst),
        .RX     (RX),
        .rx_data(rx_data),
        .rx_vld (rx_vld),
        .rx_ferr(rx_ferr)
    );

    // Loader state, image buffer and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= LOAD;
            img_q      <= '0;
            byte_cnt_q <= '0;
            pix_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            img_q      <= img_d;
            byte_cnt_q <= byte_cnt_d;
            pix_cnt_q  <= pix_cnt_d;
        end
    end

    // Next-state logic: byte packing, handshake with the core, pixel streaming.
    always_comb begin
        state_d    = state_q;
        img_d      = img_q;
        byte_cnt_d = byte_cnt_q;
        pix_cnt_d  = pix_cnt_q;
        unique case (state_q)
            LOAD: begin
                if (rx_vld) begin
                    // Bytes enter at the top so byte 0 ends up in img[7:0].
                    img_d = {rx_data, img_q[IMG_BITS-1:8]};
                    if (byte_cnt_q == LAST_BYTE) begin
                        byte_cnt_d = '0;
                        state_d    = WAIT_CORE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
                    end
                end else if (rx_ferr) begin
                    // A bad frame aborts the partial image.
                    byte_cnt_d = '0;
                end
            end
            WAIT_CORE: begin
                if (!bsy) begin
                    state_d   = STREAM;
                    pix_cnt_d = '0;
                end
            end
            STREAM: begin
                img_d = {1'b0, img_q[IMG_BITS-1:1]};
                if (pix_cnt_q == LAST_PIX) begin
                    pix_cnt_d = '0;
                    state_d   = LOAD;
                end else begin
                    pix_cnt_d = pix_cnt_q + PIX_CNT_W'(1);
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // Outputs decode straight from registers so reset clears them immediately.
    always_comb begin
        strt   = (state_q == STREAM) && (pix_cnt_q == '0);
        din    = (state_q == STREAM) ? img_q[0] : 1'b0;
        // Outside LOAD every received byte is dropped and flagged.
        rx_err = rx_ferr || (rx_vld && (state_q != LOAD));
    end

endmodule

// File: tb/tb_cnn_img_loader.sv
// Scoreboard bench for cnn_img_loader: expected images are queued when loading
// starts; a monitor pops one per strt pulse and compares the 784-pixel stream.
module tb_cnn_img_loader;
    import cnn_pkg::*;

    localparam int unsigned BD = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic RX  = 1'b1;
    logic bsy = 1'b0;
    logic strt, din, rx_err;

    cnn_img_loader #(
        .BAUD_DIV(BD)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .RX    (RX),
        .bsy   (bsy),
        .strt  (strt),
        .din   (din),
        .rx_err(rx_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    function automatic void check(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endfunction

    // Scoreboard and monitor state.
    logic [IMG_BITS-1:0] exp_q[$];
    logic [IMG_BITS-1:0] cur_exp, got_img, last_img, img;
    bit in_stream = 1'b0;
    bit post      = 1'b0;
    bit bsy_prev  = 1'b1;
    int pix = 0, lat_mode = 0, last_vld_cyc = 0, bsy_fall_cyc = 0;
    int err_cnt = 0, err_run = 0, vld_cnt = 0, stream_cnt = 0, extra_strt = 0, bad = 0;

    always @(negedge clk) begin
        if (dut.rx_vld) begin
            last_vld_cyc = cyc;
            vld_cnt++;
        end
        if (rx_err) begin
            if (err_run == 0) err_cnt++;
            err_run++;
        end else if (err_run != 0) begin
            check("rx_err_width", err_run, 1);
            err_run = 0;
        end
        if (rst) begin
            in_stream = 1'b0;
            post      = 1'b0;
        end else if (in_stream) begin
            if (strt) extra_strt++;
            got_img[pix] = din;
            pix++;
            if (pix == IMG_BITS) begin
                checks++;
                if (got_img != cur_exp) begin
                    for (int i = IMG_BITS - 1; i >= 0; i--)
                        if (got_img[i] != cur_exp[i]) bad = i;
                    errors++;
                    $display("FAIL stream%0d: pixel %0d got %0b expected %0b",
                             stream_cnt, bad, got_img[bad], cur_exp[bad]);
                end
                check("strt_extra", extra_strt, 0);
                last_img  = got_img;
                stream_cnt++;
                in_stream = 1'b0;
                post      = 1'b1;
            end
        end else begin
            if (post) begin
                check("din_after_stream", int'(din), 0);
                post = 1'b0;
            end
            if (strt) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strt", 1, 0);
                end else begin
                    cur_exp = exp_q.pop_front();
                    check("strt_while_bsy", int'(bsy_prev), 0);
                    if (lat_mode == 1) check("vld_to_strt", cyc - last_vld_cyc, 2);
                    if (lat_mode == 2) check("bsy_to_strt", cyc - bsy_fall_cyc, 1);
                    got_img    = '0;
                    got_img[0] = din;
                    pix        = 1;
                    extra_strt = 0;
                    in_stream  = 1'b1;
                end
            end
        end
        bsy_prev = bsy;
    end

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        RX = 1'b0;
        hold(BD);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            hold(BD);
        end
        RX = stop_bit;
        hold(BD);
        RX = 1'b1;
        if (!stop_bit) hold(BD);
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int n = 0;
        while ((in_stream || post || exp_q.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        hold(2);
        check(nm, int'(n < budget), 1);
    endtask

    function automatic logic [IMG_BITS-1:0] fill_img(input logic [7:0] b);
        logic [IMG_BITS-1:0] v;
        for (int k = 0; k < IMG_BYTES; k++) v[k*8 +: 8] = b;
        return v;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, s0, v0, n;

        hold(3);
        check("reset_strt", int'(strt), 0);
        check("reset_din", int'(din), 0);
        check("reset_rx_err", int'(rx_err), 0);
        rst = 1'b0;
        hold(5);
        check("idle_byte_cnt", int'(dut.byte_cnt_q), 0);

        // 98 x 0x01 with the core idle.
        lat_mode = 1;
        bsy      = 1'b0;
        exp_q.push_back(fill_img(8'h01));
        e0 = err_cnt;
        s0 = stream_cnt;
        for (int k = 0; k < IMG_BYTES; k++) send_byte(8'h01, 1'b1);
        wait_idle(1200, "t1_stream_done");
        check("t1_streams", stream_cnt - s0, 1);
        check("t1_rx_err", err_cnt - e0, 0);

        // Byte k = k with the core busy; glitch mid-load, extra byte in WAIT_CORE.
        bsy      = 1'b1;
        lat_mode = 2;
        for (int k = 0; k < IMG_BYTES; k++) img[k*8 +: 8] = 8'(k);
        exp_q.push_back(img);
        e0 = err_cnt;
        s0 = stream_cnt;
        for (int k = 0; k < 11; k++) send_byte(8'(k), 1'b1);
        v0 = vld_cnt;
        RX = 1'b0;
        hold(3);
        RX = 1'b1;
        hold(40);
        check("glitch_vld", vld_cnt - v0, 0);
        check("glitch_rx_err", err_cnt - e0, 0);
        check("glitch_byte_cnt", int'(dut.byte_cnt_q), 11);
        for (int k = 11; k < IMG_BYTES; k++) send_byte(8'(k), 1'b1);
        hold(20);
        send_byte(8'hAA, 1'b1);
        hold(20);
        check("wait_drop_rx_err", err_cnt - e0, 1);
        check("wait_byte_cnt", int'(dut.byte_cnt_q), 0);
        hold(100);
        check("t2_no_strt_while_bsy", stream_cnt - s0 + int'(in_stream), 0);
        bsy          = 1'b0;
        bsy_fall_cyc = cyc;
        wait_idle(1200, "t2_stream_done");
        check("t2_streams", stream_cnt - s0, 1);
        check("t2_pix_8_15", int'(last_img[15:8]), 8'h01);

        // 0xFF image, reset in the middle of the stream.
        lat_mode = 1;
        exp_q.push_back(fill_img(8'hFF));
        s0 = stream_cnt;
        for (int k = 0; k < IMG_BYTES; k++) send_byte(8'hFF, 1'b1);
        n = 0;
        while (!(in_stream && pix >= 300) && n < 1200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("reach_pix_300", int'(n < 1200), 1);
        check("din_before_rst", int'(din), 1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_strt", int'(strt), 0);
        check("async_rst_din", int'(din), 0);
        check("async_rst_rx_err", int'(rx_err), 0);
        hold(3);
        rst = 1'b0;
        hold(2);
        check("rst_streams", stream_cnt - s0, 0);
        check("rst_byte_cnt", int'(dut.byte_cnt_q), 0);

        // Framing error on byte 50, then a full fresh image of 0xFF.
        e0 = err_cnt;
        for (int k = 0; k < 50; k++) send_byte(8'hFF, 1'b1);
        send_byte(8'hFF, 1'b0);
        hold(30);
        check("ferr_rx_err", err_cnt - e0, 1);
        check("ferr_byte_cnt", int'(dut.byte_cnt_q), 0);
        check("ferr_no_strt", stream_cnt - s0 + int'(in_stream), 0);
        exp_q.push_back(fill_img(8'hFF));
        for (int k = 0; k < IMG_BYTES - 1; k++) send_byte(8'hFF, 1'b1);
        hold(30);
        check("byte_cnt_97", int'(dut.byte_cnt_q), 97);
        check("no_strt_at_97", stream_cnt - s0 + int'(in_stream), 0);
        send_byte(8'hFF, 1'b1);
        wait_idle(1200, "t3_stream_done");
        check("t3_streams", stream_cnt - s0, 1);
        check("t3_rx_err", err_cnt - e0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cnn_img_loader.md
# cnn_img_loader

Upstream feeder for `cnn_core`. It receives a binarized 28x28 image over a UART RX line (8N1) and packs it into a 784-bit buffer. Once `cnn_core` is idle, it starts the core and streams the image on `din`, one pixel per clock.

## Interface
- `BAUD_DIV`, 434: clocks per UART bit (50 MHz / 115200).
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `RX`  in  1  UART serial input, idle high, asynchronous to `clk`.
- `bsy`  in  1  `cnn_core` busy; a new image may start only when low.
- `strt`  out  1  one-cycle start pulse to `cnn_core`.
- `din`  out  1  serial pixel to `cnn_core`.
- `rx_err`  out  1  one-cycle pulse on framing error or dropped byte.

## Operation
- Image format:
  - 98 bytes, 784 pixels.
  - Byte k bit j (LSB first) is pixel 8k+j.
  - Pixel 0 is top-left, row-major.
- UART RX:
  - 2-flop synchronizer on `RX`.
  - Start detected on a synchronized falling edge.
  - Re-sampled at BAUD_DIV/2; if high, it was a glitch: return to idle, no error.
  - 8 data bits are sampled at mid-bit, spaced BAUD_DIV apart.
  - Stop bit is sampled at mid-bit. If 1, `rx_vld` pulses one cycle with the byte. If 0, `rx_ferr` pulses one cycle.
- Loader FSM states: LOAD, WAIT_CORE, STREAM.
  - LOAD, on `rx_vld`: `img <= {byte, img[783:8]}`, `byte_cnt++`. On the 98th byte, go to WAIT_CORE and clear `byte_cnt`.
  - LOAD, on `rx_ferr`: pulse `rx_err`, clear `byte_cnt` (partial image aborted), stay in LOAD.
  - WAIT_CORE: when `bsy`==0, go to STREAM with `pix_cnt`=0.
  - STREAM cycle 0: `strt`=1 and `din`=`img[0]`. Every STREAM cycle, `img` shifts right by one and `pix_cnt` increments. After `pix_cnt`==783, go to LOAD.
  - `din` = `img[0]` in STREAM, otherwise 0.
- Byte or framing error arriving in WAIT_CORE or STREAM:
  - The byte is dropped and `rx_err` pulses.
  - The buffered image is untouched and `byte_cnt` stays 0.
- `bsy` is ignored during STREAM. The stream is never paused.

## Timing
- Reset values:
  - All outputs 0.
  - State LOAD, `byte_cnt`=0, `pix_cnt`=0.
  - UART RX idle, synchronizer flops 1.
- Reset acts immediately, mid-byte or mid-stream. After reset, a full 98 new bytes are required.
- `rx_vld` occurs at the stop-bit mid-sample, so the last byte is accepted 9.5 bit times after its start edge, plus 2 synchronizer cycles.
- WAIT_CORE is entered the cycle after the 98th `rx_vld`.
- `strt` rises the cycle after WAIT_CORE sees `bsy`==0. Minimum latency is 2 cycles from the final `rx_vld` to `strt`.
- A stream lasts exactly 784 cycles, from the `strt` cycle to the last pixel.
- LOAD resumes the cycle after the last pixel; new bytes are accepted from that cycle.
- `rx_vld` and `rx_ferr` are mutually exclusive. A `rx_vld` on the same cycle as the WAIT_CORE→STREAM transition is dropped with `rx_err`.
- Width rules:
  - `byte_cnt` is 7 bits, range 0..97.
  - `pix_cnt` is 10 bits, range 0..783.
  - Baud counter is clog2(BAUD_DIV) bits.

## Structure
- `cnn_pkg`:
  - `IMG_BITS`=784 and `IMG_BYTES`=98, so `cnn_core` can share them.
  - Loader state enum `ld_state_t` {LOAD, WAIT_CORE, STREAM}.
- Sub-module `uart_rx`:
  - Ports `clk`, `rst`, `RX`, `rx_data[7:0]`, `rx_vld`, `rx_ferr`.
  - Parameter `BAUD_DIV`.
  - Contains the synchronizer, baud counter, bit counter and its own state machine (IDLE, START, DATA, STOP).
- The top holds the 784-bit shift register, counters and loader FSM.

## Test plan
- 98 bytes of 0x01 at BAUD_DIV=16 with `bsy`=0: one `strt` pulse 2 cycles after the last `rx_vld`; `din` = 1,0,0,0,0,0,0,0 repeating for 784 cycles, then 0.
- Byte k = k (0x00..0x61), `bsy` held 1 until 100 cycles after loading: no `strt` while `bsy`=1; `strt` 1 cycle after `bsy` falls; `din` bits 8..15 = 1,0,0,0,0,0,0,0 (byte 1).
- Stop bit forced 0 on byte 50: `rx_err` 1-cycle pulse, no `strt`. Then 98 good bytes of 0xFF: `strt` followed by 784 ones.
- 3-cycle low glitch on `RX` in idle: no `rx_vld`, no `rx_err`, `byte_cnt` unchanged.
- Byte sent while in WAIT_CORE (`bsy`=1): `rx_err` pulse. The later stream still equals the original image.
- `rst` asserted at pixel 300: `strt`, `din` and `rx_err` go 0 without waiting for a clock edge. After release, no `strt` until 98 new bytes are received.
